ddr_cmd_sequencer: RTL and testbench

- Converts single-beat read/write requests (bank, row, column, 16-bit data) into a DRAM command stream of ACTIVATE, READ, WRITE, PRECHARGE and NOP, with tRP/tRCD spacing.
- Keeps an open-row table for the 4 banks, so row hits skip activation and row conflicts precharge first.
- Sits between the testbench stimulus generator and the DRAM model command bus.
- Monitors sample its command bus and build packets from it.

---
 rtl/ddr_cmd_sequencer.sv | 174 +++++++++++++++++
 tb/tb_ddr_cmd_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ddr_cmd_sequencer.sv
// ddr_cmd_sequencer: request-to-DRAM command sequencer with open-row table and tRP/tRCD spacing.
// Optional refresh engine enabled by defining DDR_SEQ_REFRESH_EN.
module ddr_cmd_sequencer #(
  parameter int TRP   = 3,
  parameter int TRCD  = 3,
  parameter int TRFC  = 8,
  parameter int TREFI = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_cmd,
  input  logic [1:0]  req_bank,
  input  logic [12:0] req_row,
  input  logic [9:0]  req_col,
  input  logic [15:0] req_data,
  output logic [2:0]  cmd_out,
  output logic [1:0]  ba_out,
  output logic [12:0] addr_out,
  output logic [15:0] wdata_out,
  output logic        wdata_oe
);
  localparam logic [2:0] C_NOP = 3'd0, C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3, C_PRE = 3'd4, C_REF = 3'd5;
  typedef enum logic [3:0] {
    IDLE, PRE, TRP_WAIT, ACT, TRCD_WAIT, ACCESS
`ifdef DDR_SEQ_REFRESH_EN
    , RPRE, RTRP, RREF, RTRFC
`endif
  } state_t;
  state_t      r_state, w_next;
  logic [7:0]  r_timer, w_timer;
  logic [3:0]  r_valid;
  logic [12:0] r_row [4];
  logic        r_wr;
  logic [1:0]  r_bank;
  logic [12:0] r_arow;
  logic [9:0]  r_col;
  logic [15:0] r_data;
  logic [2:0]  w_cmd;
  logic [1:0]  w_ba;
  logic [12:0] w_addr;
  logic [15:0] w_wdata;
  logic        w_oe, w_acc, w_hit, w_clr;
`ifdef DDR_SEQ_REFRESH_EN
  localparam int RW = $clog2(TREFI);
  logic [RW-1:0] r_refi;
  logic          r_pend, w_wrap;
  assign w_wrap    = r_refi == RW'(TREFI - 1);
  assign req_ready = r_state == IDLE && !r_pend;
`else
  assign req_ready = r_state == IDLE;
`endif
  assign w_acc = req_valid && req_ready && req_cmd[2:1] == 2'b01;
  assign w_hit = r_valid[req_bank] && r_row[req_bank] == req_row;
  always_comb begin
    w_next  = r_state;
    w_timer = r_timer;
    w_cmd   = C_NOP;
    w_ba    = '0;
    w_addr  = '0;
    w_wdata = '0;
    w_oe    = 1'b0;
    w_clr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_acc) w_next = w_hit ? ACCESS : r_valid[req_bank] ? PRE : ACT;
`ifdef DDR_SEQ_REFRESH_EN
        if (r_pend) w_next = |r_valid ? RPRE : RREF;
`endif
      end
      PRE: begin
        w_cmd   = C_PRE;
        w_ba    = r_bank;
        w_timer = 8'(TRP - 1);
        w_next  = TRP == 1 ? ACT : TRP_WAIT;
      end
      TRP_WAIT: begin
        w_timer = r_timer - 8'd1;
        w_next  = r_timer == 8'd1 ? ACT : TRP_WAIT;
      end
      ACT: begin
        w_cmd   = C_ACT;
        w_ba    = r_bank;
        w_addr  = r_arow;
        w_timer = 8'(TRCD - 1);
        w_next  = TRCD == 1 ? ACCESS : TRCD_WAIT;
      end
      TRCD_WAIT: begin
        w_timer = r_timer - 8'd1;
        w_next  = r_timer == 8'd1 ? ACCESS : TRCD_WAIT;
      end
      ACCESS: begin
        w_cmd   = r_wr ? C_WR : C_RD;
        w_ba    = r_bank;
        w_addr  = {3'b0, r_col};
        w_oe    = r_wr;
        w_wdata = r_wr ? r_data : '0;
        w_next  = IDLE;
      end
`ifdef DDR_SEQ_REFRESH_EN
      RPRE: begin
        w_cmd   = C_PRE;
        w_addr  = 13'h0400;
        w_timer = 8'(TRP - 1);
        w_next  = TRP == 1 ? RREF : RTRP;
      end
      RTRP: begin
        w_timer = r_timer - 8'd1;
        w_next  = r_timer == 8'd1 ? RREF : RTRP;
      end
      RREF: begin
        w_cmd   = C_REF;
        w_timer = 8'(TRFC - 1);
        w_clr   = TRFC == 1;
        w_next  = TRFC == 1 ? IDLE : RTRFC;
      end
      RTRFC: begin
        w_timer = r_timer - 8'd1;
        w_clr   = r_timer == 8'd1;
        w_next  = r_timer == 8'd1 ? IDLE : RTRFC;
      end
`endif
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_valid   <= '0;
      r_row     <= '{default: '0};
      r_wr      <= 1'b0;
      r_bank    <= '0;
      r_arow    <= '0;
      r_col     <= '0;
      r_data    <= '0;
      cmd_out   <= C_NOP;
      ba_out    <= '0;
      addr_out  <= '0;
      wdata_out <= '0;
      wdata_oe  <= 1'b0;
`ifdef DDR_SEQ_REFRESH_EN
      r_refi    <= '0;
      r_pend    <= 1'b0;
`endif
    end else begin
      r_state   <= w_next;
      r_timer   <= w_timer;
      cmd_out   <= w_cmd;
      ba_out    <= w_ba;
      addr_out  <= w_addr;
      wdata_out <= w_wdata;
      wdata_oe  <= w_oe;
      if (w_acc) begin
        r_wr   <= req_cmd[0];
        r_bank <= req_bank;
        r_arow <= req_row;
        r_col  <= req_col;
        r_data <= req_data;
      end
      if (r_state == PRE) r_valid[r_bank] <= 1'b0;
      if (r_state == ACT) begin
        r_valid[r_bank] <= 1'b1;
        r_row[r_bank]   <= r_arow;
      end
`ifdef DDR_SEQ_REFRESH_EN
      if (r_state == RPRE) r_valid <= '0;
      r_refi <= w_wrap ? '0 : r_refi + 1'b1;
      r_pend <= w_wrap ? 1'b1 : w_clr ? 1'b0 : r_pend;
`endif
    end
  end
endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// tb_ddr_cmd_sequencer: scoreboard bench; expected commands with their cycle are queued at handshake.
module tb_ddr_cmd_sequencer;
  localparam int TRP = 3, TRCD = 3;
  logic        clk = 0, reset = 1, req_valid = 0, req_ready;
  logic [2:0]  req_cmd = 0, cmd_out;
  logic [1:0]  req_bank = 0, ba_out;
  logic [12:0] req_row = 0, addr_out;
  logic [9:0]  req_col = 0;
  logic [15:0] req_data = 0, wdata_out;
  logic        wdata_oe;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {
    logic [2:0]  c;
    logic [1:0]  b;
    logic [12:0] a;
    logic        oe;
    logic [15:0] d;
    int          t;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic        tb_valid [4];
  logic [12:0] tb_row [4];
  ddr_cmd_sequencer #(.TRP(TRP), .TRCD(TRCD)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .req_data(req_data), .cmd_out(cmd_out), .ba_out(ba_out), .addr_out(addr_out),
    .wdata_out(wdata_out), .wdata_oe(wdata_oe)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h at cycle %0d", tag, act, exp, cyc);
    end
  endtask
  task automatic push(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                      input logic oe, input logic [15:0] d, input int t);
    exp_t x;
    x.c = c; x.b = b; x.a = a; x.oe = oe; x.d = d; x.t = t;
    q.push_back(x);
  endtask
  always @(negedge clk) if (!reset && cmd_out != 3'd0) begin
    if (q.size() == 0) chk("unexpected_cmd", 32'(cmd_out), 32'd0);
    else begin
      e = q.pop_front();
      chk("cmd", 32'(cmd_out), 32'(e.c));
      chk("ba", 32'(ba_out), 32'(e.b));
      chk("addr", 32'(addr_out), 32'(e.a));
      chk("oe", 32'(wdata_oe), 32'(e.oe));
      chk("wdata", 32'(wdata_out), 32'(e.d));
      chk("cycle", cyc, e.t);
    end
  end
  task automatic drive(input logic [2:0] c, input logic [1:0] b, input logic [12:0] r,
                       input logic [9:0] col, input logic [15:0] d);
    int t;
    @(negedge clk);
    chk("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1; req_cmd = c; req_bank = b; req_row = r; req_col = col; req_data = d;
    t = cyc + 2;
    if (c == 3'd2 || c == 3'd3) begin
      if (tb_valid[b] && tb_row[b] != r) begin
        push(3'd4, b, 13'd0, 1'b0, 16'd0, t);
        t += TRP;
      end
      if (!(tb_valid[b] && tb_row[b] == r)) begin
        push(3'd1, b, r, 1'b0, 16'd0, t);
        t += TRCD;
        tb_valid[b] = 1;
        tb_row[b] = r;
      end
      push(c, b, {3'b0, col}, c == 3'd3, c == 3'd3 ? d : 16'd0, t);
    end
    @(negedge clk);
    req_valid = 0;
  endtask
  task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [12:0] r,
                       input logic [9:0] col, input logic [15:0] d);
    drive(c, b, r, col, d);
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < 4; i++) begin tb_valid[i] = 0; tb_row[i] = 0; end
    repeat (2) @(negedge clk);
    chk("rst_cmd", 32'(cmd_out), 32'd0);
    chk("rst_ba", 32'(ba_out), 32'd0);
    chk("rst_addr", 32'(addr_out), 32'd0);
    chk("rst_wdata", 32'(wdata_out), 32'd0);
    chk("rst_oe", 32'(wdata_oe), 32'd0);
    reset = 0;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    issue(3'd3, 2'd0, 13'h0055, 10'h012, 16'hBEEF);
    issue(3'd2, 2'd0, 13'h0055, 10'h020, 16'h0);
    issue(3'd2, 2'd2, 13'h0AAA, 10'h001, 16'h0);
    issue(3'd2, 2'd0, 13'h1FFF, 10'h003, 16'h0);
    issue(3'd2, 2'd2, 13'h0AAA, 10'h005, 16'h0);
    issue(3'd3, 2'd1, 13'h0007, 10'h3FF, 16'h1234);
    issue(3'd3, 2'd1, 13'h0008, 10'h000, 16'h5A5A);
    issue(3'd0, 2'd1, 13'h0009, 10'h001, 16'hFFFF);
    chk("noop_ready", 32'(req_ready), 32'd1);
    issue(3'd7, 2'd3, 13'h0001, 10'h001, 16'h0);
    chk("noop7_ready", 32'(req_ready), 32'd1);
    begin
      int t;
      @(negedge clk);
      req_valid = 1; req_cmd = 3'd3; req_bank = 2'd3; req_row = 13'h0123; req_col = 10'h0AB; req_data = 16'hCAFE;
      t = cyc + 2;
      push(3'd1, 2'd3, 13'h0123, 1'b0, 16'd0, t);
      @(negedge clk);
      req_valid = 0;
      repeat (2) @(negedge clk);
      chk("pre_rst_drained", 32'(q.size()), 32'd0);
      reset = 1;
      #1;
      chk("midrst_cmd", 32'(cmd_out), 32'd0);
      chk("midrst_oe", 32'(wdata_oe), 32'd0);
      q.delete();
      for (int i = 0; i < 4; i++) tb_valid[i] = 0;
      repeat (2) @(negedge clk);
      reset = 0;
      repeat (6) @(negedge clk);
    end
    issue(3'd2, 2'd3, 13'h0123, 10'h0AB, 16'h0);
    issue(3'd2, 2'd0, 13'h1FFF, 10'h010, 16'h0);
    for (int k = 0; k < 12; k++) begin
      logic [2:0] c;
      c = $urandom_range(0, 1) != 0 ? 3'd2 : 3'd3;
      issue(c, 2'($urandom_range(0, 3)), 13'($urandom_range(0, 2)), 10'($urandom_range(0, 1023)),
            16'($urandom_range(0, 65535)));
    end
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
